// File: rtl/spi_flash_xip_apb.sv
// APB read-only window onto serial flash: reads hit a one-word buffer or are
// fetched over SPI mode 0 with a READ (0x03) or FAST_READ (0x0B) command.
module spi_flash_xip_apb #(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
  parameter int unsigned SS_NUM     = 8,
  parameter int unsigned SS_IDX     = 0,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FAST_READ  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       in_paddr,
  input  logic              in_psel,
  input  logic              in_penable,
  input  logic              in_pwrite,
  input  logic [31:0]       in_pwdata,
  input  logic [3:0]        in_pstrb,
  output logic              in_pready,
  output logic [31:0]       in_prdata,
  output logic              in_pslverr,
  output logic              spi_sck,
  output logic [SS_NUM-1:0] spi_ss,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam logic [7:0]        DIV_LAST = 8'(CLK_DIV - 1);
  localparam bit                FAST     = (FAST_READ != 0);
  localparam logic [7:0]        CMD_BYTE = FAST ? 8'h0B : 8'h03;
  localparam logic [SS_NUM-1:0] SS_IDLE  = '1;
  localparam logic [SS_NUM-1:0] SS_SEL   = ~(SS_NUM'(1) << SS_IDX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [4:0]        bit_q, bit_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [SS_NUM-1:0] ss_q, ss_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic [21:0]       req_tag_q, req_tag_d;
  logic              abort_q, abort_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              buf_valid_q, buf_valid_d;
  logic [21:0]       buf_tag_q, buf_tag_d;
  logic [31:0]       buf_data_q, buf_data_d;

  logic        setup_c;
  logic        in_range_c;
  logic        hit_c;
  logic        half_end_c;
  logic [31:0] rx_word_c;
  logic        unused_inputs;

  assign unused_inputs = ^{in_pwdata, in_pstrb};

  assign setup_c    = in_psel && !in_penable;
  assign in_range_c = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign hit_c      = buf_valid_q && (buf_tag_q == in_paddr[23:2]);
  assign half_end_c = (div_q == DIV_LAST);
  // First byte on the wire lands in the least significant byte
  assign rx_word_c  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    ss_d        = ss_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    req_tag_d   = req_tag_q;
    abort_d     = abort_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = prdata_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (setup_c) begin
          if (in_pwrite || !in_range_c) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else if (hit_c) begin
            pready_d = 1'b1;
            prdata_d = buf_data_q;
          end else begin
            state_d   = S_CMD;
            div_d     = '0;
            bit_d     = 5'd7;
            sck_d     = 1'b0;
            ss_d      = SS_SEL;
            tx_d      = {CMD_BYTE, in_paddr[23:2], 2'b00};
            mosi_d    = CMD_BYTE[7];
            rx_d      = '0;
            req_tag_d = in_paddr[23:2];
            abort_d   = 1'b0;
          end
        end
      end

      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (!in_psel) abort_d = 1'b1;
        if (!half_end_c) begin
          div_d = div_q + 8'd1;
        end else if (!sck_q) begin
          div_d = '0;
          sck_d = 1'b1;
          if (state_q == S_DATA) rx_d = {rx_q[30:0], spi_miso};
        end else begin
          // Bit boundary: SCK falls and MOSI advances; ones fill in after the address
          div_d  = '0;
          sck_d  = 1'b0;
          tx_d   = {tx_q[30:0], 1'b1};
          mosi_d = tx_q[30];
          bit_d  = bit_q - 5'd1;
          if (bit_q == 5'd0) begin
            case (state_q)
              S_CMD: begin
                state_d = S_ADDR;
                bit_d   = 5'd23;
              end
              S_ADDR: begin
                state_d = FAST ? S_DUMMY : S_DATA;
                bit_d   = FAST ? 5'd7 : 5'd31;
              end
              S_DUMMY: begin
                state_d = S_DATA;
                bit_d   = 5'd31;
              end
              default: begin
                state_d     = S_DONE;
                bit_d       = '0;
                ss_d        = SS_IDLE;
                mosi_d      = 1'b1;
                pready_d    = in_psel && !abort_q;
                prdata_d    = rx_word_c;
                buf_valid_d = 1'b1;
                buf_tag_d   = req_tag_q;
                buf_data_d  = rx_word_c;
              end
            endcase
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b1;
      ss_q        <= SS_IDLE;
      tx_q        <= '1;
      rx_q        <= '0;
      req_tag_q   <= '0;
      abort_q     <= 1'b0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      req_tag_q   <= req_tag_d;
      abort_q     <= abort_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign in_pready  = pready_q;
  assign in_pslverr = pslverr_q;
  assign in_prdata  = prdata_q;
  assign spi_sck    = sck_q;
  assign spi_ss     = ss_q;
  assign spi_mosi   = mosi_q;

endmodule
